// File: rtl/ap_ctrl_stat_monitor.sv
// Passive per-channel ap_ctrl_hs/ap_ctrl_chain statistics monitor with a registered read port.
// Read latency 1 cycle; observes handshakes only and never backpressures them.
module ap_ctrl_stat_monitor #(
  parameter  int NUM_CH = 2,
  parameter  int CNT_W  = 32,
  parameter  int LAT_W  = 24,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int DW     = (CNT_W > LAT_W) ? CNT_W : LAT_W
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              freeze,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [LAT_W-1:0] LMAX = '1;

  state_t           st        [NUM_CH];
  logic [LAT_W-1:0] lat_cnt   [NUM_CH];
  logic [LAT_W-1:0] ii_cnt    [NUM_CH];
  logic [CNT_W-1:0] txn_cnt   [NUM_CH];
  logic [CNT_W-1:0] stall_cnt [NUM_CH];
  logic [LAT_W-1:0] lat_last  [NUM_CH];
  logic [LAT_W-1:0] lat_min   [NUM_CH];
  logic [LAT_W-1:0] lat_max   [NUM_CH];
  logic [LAT_W-1:0] ii_last   [NUM_CH];
  logic [NUM_CH-1:0] ii_valid;
  logic [NUM_CH-1:0] ii_seen;
  logic [NUM_CH-1:0] ovf;

  logic [NUM_CH-1:0] cmpl;
  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] lat_sat;
  logic [LAT_W-1:0]  lat_now [NUM_CH];
  logic [DW-1:0]     rd_mux;

  // Completion is ap_done seen while launching from IDLE or while in RUN; HOLD ignores ap_done.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cmpl[i]    = ap_done[i] & (((st[i] == IDLE) & ap_start[i]) | (st[i] == RUN));
      stall[i]   = ~ap_continue[i] & (cmpl[i] | (st[i] == HOLD));
      lat_sat[i] = (st[i] == RUN) && (lat_cnt[i] == LMAX);
      if (st[i] != RUN) begin
        lat_now[i] = '0;
      end else if (lat_sat[i]) begin
        lat_now[i] = LMAX;
      end else begin
        lat_now[i] = lat_cnt[i] + LAT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]        <= IDLE;
        lat_cnt[i]   <= '0;
        ii_cnt[i]    <= '0;
        txn_cnt[i]   <= '0;
        stall_cnt[i] <= '0;
        lat_last[i]  <= '0;
        lat_min[i]   <= LMAX;
        lat_max[i]   <= '0;
        ii_last[i]   <= '0;
      end
      ii_valid <= '0;
      ii_seen  <= '0;
      ovf      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (st[i])
          IDLE: begin
            if (ap_start[i]) begin
              lat_cnt[i] <= '0;
              if (!ap_done[i]) begin
                st[i] <= RUN;
              end else if (!ap_continue[i]) begin
                st[i] <= HOLD;
              end
            end
          end
          RUN: begin
            if (!lat_sat[i]) lat_cnt[i] <= lat_cnt[i] + LAT_W'(1);
            if (ap_done[i]) st[i] <= ap_continue[i] ? IDLE : HOLD;
          end
          HOLD: begin
            if (ap_continue[i]) st[i] <= IDLE;
          end
          default: st[i] <= IDLE;
        endcase

        if (ap_ready[i]) begin
          ii_cnt[i] <= LAT_W'(1);
        end else if (ii_cnt[i] != LMAX) begin
          ii_cnt[i] <= ii_cnt[i] + LAT_W'(1);
        end

        // Clear beats any same-cycle update; freeze only gates statistics, not tracking.
        if (clear) begin
          txn_cnt[i]   <= '0;
          stall_cnt[i] <= '0;
          lat_last[i]  <= '0;
          lat_min[i]   <= LMAX;
          lat_max[i]   <= '0;
          ii_last[i]   <= '0;
          ii_valid[i]  <= 1'b0;
          ii_seen[i]   <= 1'b0;
          ovf[i]       <= 1'b0;
        end else begin
          if (ap_ready[i]) ii_seen[i] <= 1'b1;
          if (!freeze) begin
            if (cmpl[i]) begin
              if (txn_cnt[i] == CMAX) ovf[i] <= 1'b1;
              else txn_cnt[i] <= txn_cnt[i] + CNT_W'(1);
              if (lat_sat[i]) ovf[i] <= 1'b1;
              lat_last[i] <= lat_now[i];
              if (lat_now[i] < lat_min[i]) lat_min[i] <= lat_now[i];
              if (lat_now[i] > lat_max[i]) lat_max[i] <= lat_now[i];
            end
            if (stall[i]) begin
              if (stall_cnt[i] == CMAX) ovf[i] <= 1'b1;
              else stall_cnt[i] <= stall_cnt[i] + CNT_W'(1);
            end
            if (ap_ready[i] && ii_seen[i]) begin
              ii_last[i]  <= ii_cnt[i];
              ii_valid[i] <= 1'b1;
              if (ii_cnt[i] == LMAX) ovf[i] <= 1'b1;
            end
          end
        end
      end

      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (32'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0:    rd_mux = DW'(txn_cnt[rd_ch]);
        3'd1:    rd_mux = DW'(lat_last[rd_ch]);
        3'd2:    rd_mux = DW'(lat_min[rd_ch]);
        3'd3:    rd_mux = DW'(lat_max[rd_ch]);
        3'd4:    rd_mux = DW'(ii_last[rd_ch]);
        3'd5:    rd_mux = DW'(stall_cnt[rd_ch]);
        3'd6:    rd_mux = DW'({ovf[rd_ch], ii_valid[rd_ch], st[rd_ch]});
        default: rd_mux = '0;
      endcase
    end
  end

endmodule
